// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port DataMemory between port A (CPU LSU) and port B (debug/loader).
// Optional build macro DMEM_ARB_ALIGN_CHECK_EN adds address-alignment and byte-lane pattern rejection.
module data_memory_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
  parameter int unsigned SIZE_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_byte_sel,
  output logic        a_gnt,
  output logic        a_rsp_valid,
  output logic        a_rsp_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_byte_sel,
  output logic        b_gnt,
  output logic        b_rsp_valid,
  output logic        b_rsp_err,
  output logic [31:0] b_rdata,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [3:0]  mem_byte_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(SIZE_BYTES);

  state_t      state_q;
  logic        owner_q;       // 1 = port B
  logic        last_owner_q;  // 1 = port B
  logic        we_q;
  logic        err_q;
  logic        mem_re_q;
  logic        mem_we_q;
  logic [3:0]  mem_bsel_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        a_rsp_valid_q, b_rsp_valid_q;
  logic        a_rsp_err_q, b_rsp_err_q;

  logic        grant_any;
  logic        pick_b;
  logic        we_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic [3:0]  bsel_d;
  logic        err_d;

  // On a tie the port that did not win last time gets the grant.
  assign grant_any = (state_q == S_IDLE) && (a_req || b_req) && !reset;
  assign pick_b    = b_req && (!a_req || !last_owner_q);
  assign a_gnt     = grant_any && !pick_b;
  assign b_gnt     = grant_any && pick_b;

  assign we_d    = pick_b ? b_we       : a_we;
  assign addr_d  = pick_b ? b_addr     : a_addr;
  assign wdata_d = pick_b ? b_wdata    : a_wdata;
  assign bsel_d  = pick_b ? b_byte_sel : a_byte_sel;

  always_comb begin
    err_d = (addr_d < BASE_ADDR) || ({1'b0, addr_d} >= WIN_END);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    if (addr_d[1:0] != 2'b00) err_d = 1'b1;
    case (bsel_d)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ;
      default: err_d = 1'b1;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_bsel_q    <= 4'b0000;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_err_q   <= 1'b0;
      b_rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          a_rsp_valid_q <= 1'b0;
          b_rsp_valid_q <= 1'b0;
          a_rsp_err_q   <= 1'b0;
          b_rsp_err_q   <= 1'b0;
          if (grant_any) begin
            owner_q      <= pick_b;
            last_owner_q <= pick_b;
            we_q         <= we_d;
            err_q        <= err_d;
            // Rejected accesses still present address/lanes but never enable the memory.
            mem_re_q     <= ~we_d & ~err_d;
            mem_we_q     <= we_d & ~err_d;
            mem_bsel_q   <= bsel_d;
            mem_addr_q   <= {addr_d[31:2], 2'b00};
            mem_wdata_q  <= wdata_d;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_re_q      <= 1'b0;
          mem_we_q      <= 1'b0;
          mem_bsel_q    <= 4'b0000;
          mem_addr_q    <= 32'h0;
          mem_wdata_q   <= 32'h0;
          a_rsp_valid_q <= ~owner_q;
          b_rsp_valid_q <= owner_q;
          a_rsp_err_q   <= ~owner_q & err_q;
          b_rsp_err_q   <= owner_q & err_q;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          a_rsp_valid_q <= 1'b0;
          b_rsp_valid_q <= 1'b0;
          a_rsp_err_q   <= 1'b0;
          b_rsp_err_q   <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_read_enable  = mem_re_q;
  assign mem_write_enable = mem_we_q;
  assign mem_byte_sel     = mem_bsel_q;
  assign mem_addr         = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;

  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign a_rsp_err   = a_rsp_err_q;
  assign b_rsp_err   = b_rsp_err_q;
  // Read data arrives from the memory during the response cycle itself.
  assign a_rdata = (a_rsp_valid_q && !a_rsp_err_q && !we_q) ? mem_read_data : 32'h0;
  assign b_rdata = (b_rsp_valid_q && !b_rsp_err_q && !we_q) ? mem_read_data : 32'h0;

endmodule
